// File: rtl/cpu_div_unit.sv
// cpu_div_unit: iterative restoring divider for DIV/DIVU/REM/REMU in the
// execute stage. A normal divide stalls the pipeline for 33 cycles and
// presents its result in the DONE cycle. Divide-by-zero and signed overflow
// are answered combinationally in the start cycle without stalling.
module cpu_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            stall_req,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic            rem_sel_q, rem_sel_d;   // 1: remainder wanted (op[1])
   logic            qneg_q, qneg_d;         // negate quotient at the end
   logic            rneg_q, rneg_d;         // negate remainder at the end
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_signed, a_neg, b_neg;
   logic            div_zero, sgn_ovf, fast_hit;
   logic [XLEN-1:0] fast_val;
   logic [XLEN:0]   rem_sh, trial;
   logic [XLEN-1:0] step_rem, step_quo, fin_rem, fin_quo;

   // Operand decode and one restoring step of the {remainder, quotient} pair
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & dividend[XLEN-1];
      b_neg     = is_signed & divisor[XLEN-1];
      div_zero  = (divisor == '0);
      sgn_ovf   = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                            && (divisor == '1);
      fast_hit  = div_zero | sgn_ovf;
      if (div_zero)
         fast_val = op[1] ? dividend : '1;
      else
         fast_val = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

      // 33-bit trial subtract: the shifted remainder can exceed 32 bits.
      rem_sh   = {rem_q, quo_q[XLEN-1]};
      trial    = rem_sh - {1'b0, dvsr_q};
      step_rem = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
      step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
      fin_quo  = qneg_q ? -step_quo : step_quo;
      fin_rem  = rneg_q ? -step_rem : step_rem;
   end

   // Next-state, datapath next values and outputs
   always_comb begin
      state_d      = state_q;
      rem_sel_d    = rem_sel_q;
      qneg_d       = qneg_q;
      rneg_d       = rneg_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      dvsr_d       = dvsr_q;
      result_d     = result_q;
      stall_req    = 1'b0;
      result_valid = 1'b0;
      result       = result_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               if (fast_hit) begin
                  result_valid = 1'b1;
                  result       = fast_val;
                  result_d     = fast_val;
               end else begin
                  stall_req = 1'b1;
                  rem_sel_d = op[1];
                  qneg_d    = a_neg ^ b_neg;
                  rneg_d    = a_neg;
                  quo_d     = a_neg ? -dividend : dividend;
                  dvsr_d    = b_neg ? -divisor : divisor;
                  rem_d     = '0;
                  cnt_d     = 6'd32;
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            stall_req = 1'b1;
            rem_d     = step_rem;
            quo_d     = step_quo;
            cnt_d     = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = DONE;
               if (!flush)
                  result_d = rem_sel_q ? fin_rem : fin_quo;
            end
         end
         DONE: begin
            // start is still the same instruction here, so it is ignored.
            result_valid = ~flush;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush)
         state_d = IDLE;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         rem_sel_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         rem_sel_q <= rem_sel_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
      end
   end

endmodule

// File: tb/tb_cpu_div_unit.sv
// Testbench for cpu_div_unit: directed divide operations checked every cycle
// against an arithmetic model of the result and the 34-cycle stall timeline.
module tb_cpu_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] dividend, divisor;
   logic        stall_req, result_valid;
   logic [31:0] result;

   int          errors = 0;
   int          checks = 0;

   logic        chk_en = 1'b0;
   logic        chk_res = 1'b0;
   logic        exp_stall = 1'b0;
   logic        exp_valid = 1'b0;
   logic [31:0] exp_res = '0;

   localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

   always #5 clk = ~clk;

   cpu_div_unit #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .op           (op),
      .dividend     (dividend),
      .divisor      (divisor),
      .flush        (flush),
      .stall_req    (stall_req),
      .result_valid (result_valid),
      .result       (result)
   );

   // RISC-V M-extension semantics in plain arithmetic
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      logic want_rem;
      sgn      = ~o[0];
      want_rem = o[1];
      if (b == 32'd0)
         return want_rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return want_rem ? 32'd0 : 32'h8000_0000;
      if (sgn)
         return want_rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      return want_rem ? a % b : a / b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Compare the DUT against the expected timeline away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
         chk("result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
         if (exp_valid || chk_res)
            chk("result", result, exp_res);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic check_result, input logic [31:0] held);
      start     = 1'b0;
      flush     = 1'b0;
      chk_en    = 1'b1;
      exp_stall = 1'b0;
      exp_valid = 1'b0;
      chk_res   = check_result;
      exp_res   = held;
      for (int i = 0; i < n; i++) step();
   endtask

   // One divide: start in cycle 0, optional flush/reset abort, optional
   // operand scrambling while the divide is running.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int flush_cyc, input int rst_cyc,
                         input logic garble);
      logic [31:0] expv;
      logic        fast;
      expv = model(o, a, b);
      chk("model", expv, lit);
      fast = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      $display("op=%0d a=%h b=%h expect=%h fast=%0d flush@%0d rst@%0d", o, a, b, expv, fast, flush_cyc, rst_cyc);
      start     = 1'b1;
      op        = o;
      dividend  = a;
      divisor   = b;
      flush     = 1'b0;
      rst       = 1'b0;
      chk_en    = 1'b1;
      chk_res   = 1'b0;
      exp_stall = ~fast;
      exp_valid = fast;
      exp_res   = expv;
      step();
      start = 1'b0;
      if (fast) return;
      for (int c = 1; c <= 33; c++) begin
         if (garble) begin
            dividend = $urandom;
            divisor  = $urandom;
            op       = 2'($urandom_range(0, 3));
         end
         if (c == flush_cyc || c == rst_cyc) begin
            flush  = (c == flush_cyc);
            rst    = (c == rst_cyc);
            chk_en = 1'b0;
         end else if (c == flush_cyc + 1 || c == rst_cyc + 1) begin
            flush     = 1'b0;
            rst       = 1'b0;
            chk_en    = 1'b1;
            exp_stall = 1'b0;
            exp_valid = 1'b0;
            chk_res   = (c == rst_cyc + 1);
            exp_res   = 32'd0;
            step();
            return;
         end else begin
            chk_en    = 1'b1;
            exp_stall = (c <= 32);
            exp_valid = (c == 33);
         end
         step();
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      flush    = 1'b0;
      op       = 2'd0;
      dividend = '0;
      divisor  = '0;
      step();
      step();
      rst = 1'b0;
      idle(2, 1'b1, 32'd0);                                  // reset state

      run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, -1, -1, 1'b0);
      run_op(OP_REMU, 32'd100, 32'd7, 32'd2, -1, -1, 1'b0);   // back-to-back
      idle(2, 1'b1, 32'd2);                                  // result holds

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, -1, 1'b0);
      run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, -1, 1'b0);

      run_op(OP_DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, -1, -1, 1'b0);
      run_op(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, -1, -1, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1, 1'b0);
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, -1, 1'b0);
      idle(1, 1'b1, 32'd0);

      run_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, 10, -1, 1'b0);
      run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, -1, -1, 1'b0);

      run_op(OP_DIVU, 32'd50, 32'd5, 32'd10, -1, 5, 1'b0);
      run_op(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'hD555_5556, -1, -1, 1'b1);
      run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, -1, -1, 1'b1);
      run_op(OP_DIVU, 32'h8000_0000, 32'd1, 32'h8000_0000, -1, -1, 1'b0);
      run_op(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, -1, -1, 1'b0);
      run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, -1, -1, 1'b0);
      idle(3, 1'b1, 32'd1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_div_unit.md
# cpu_div_unit

Iterative 32-bit integer divider for the execute stage of the pipelined RV32 core. It implements DIV, DIVU, REM and REMU. While a division is in flight it raises a stall request, which the hazard logic turns into stall_f, stall_d and stall_e. The block is the requesting side of the pipeline stall protocol: it produces the multi-cycle stall condition, and the hazard unit consumes it.

## Interface

Parameters:
- XLEN, 32, operand and result width (only 32 is supported)

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- start  input  1  a divide/remainder instruction is valid in E this cycle
- op  input  2  funct3[1:0]: 0 DIV, 1 DIVU, 2 REM, 3 REMU
- dividend  input  32  forwarded rs1 value (E stage)
- divisor  input  32  forwarded rs2 value (E stage)
- flush  input  1  kill the E-stage instruction (from flush_e)
- stall_req  output  1  hold F/D/E; combinational
- result_valid  output  1  result is valid this cycle
- result  output  32  quotient or remainder

## Operation

- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values:
  - result_valid = 0, result = 0, iteration counter = 0.
  - stall_req = 0, provided start is low.
- IDLE, start=1, flush=0, normal case:
  - Latch op, the operand magnitudes and the sign flags. For DIVU/REMU the magnitudes are the raw operands.
  - Clear the partial remainder and load counter = 32.
  - Go to RUN.
  - stall_req = 1 in this same cycle, combinationally.
- IDLE, start=1, fast cases (stay in IDLE; result_valid = 1 combinationally; stall_req = 0):
  - divisor == 0: quotient = 0xFFFFFFFF; remainder = dividend.
  - Signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- RUN: one restoring step per cycle.
  - Shift the {remainder, quotient} pair left by one bit.
  - Trial-subtract the divisor magnitude with a 33-bit subtract. If the result is non-negative, keep it and set the quotient LSB.
  - Decrement counter. stall_req = 1 throughout.
  - After the step that takes counter to 0, go to DONE.
- DONE:
  - Apply signs. The quotient is negated when the dividend and divisor signs differ (signed ops only). The remainder takes the dividend's sign.
  - result_valid = 1; result is registered (quotient for op[1]=0, remainder for op[1]=1).
  - stall_req = 0. start is ignored, because it is the same instruction still present.
  - Next state is IDLE.
- Magnitudes: |0x80000000| = 0x80000000 as unsigned, which is exact in 32 bits. No overflow is possible inside the loop.
- Operands are sampled only on the IDLE start cycle. Input changes during RUN (for example forwarding updates) are ignored.
- Flush:
  - Any state with flush=1: next state is IDLE, and result_valid is forced to 0 that cycle.
  - In the IDLE+start cycle, flush wins: no latch, stall_req = 0.
- start=0 in IDLE: outputs hold at 0, the block stays idle, and result keeps its last value.
- Reset mid-operation: next cycle is IDLE with every output at its reset value, and no result_valid is ever produced for the aborted op.

## Timing

- Normal latency:
  - Cycle 0: IDLE with start.
  - Cycles 1–32: RUN, 32 iterations.
  - Cycle 33: DONE, result_valid = 1.
- stall_req is high in cycles 0–32, so the instruction occupies E for 34 cycles.
- Fast-path latency is 0 extra cycles: result_valid in cycle 0, no stall.
- Back-to-back: a second divide reaching E in cycle 34 is accepted at its own start. There are no dead cycles beyond DONE.
- result_valid is never high for more than one cycle per accepted op.
- stall_req depends combinationally only on state, start, flush and the fast-case detect. It has no path from result.

## Test plan

- DIVU 100 / 7 (start in cycle 0):
  - stall_req high in cycles 0–32.
  - Cycle 33: result_valid = 1, result = 14.
  - REMU with the same operands gives 2.
- DIV 0xFFFFFFF9 (−7) / 2: result 0xFFFFFFFD (−3) at cycle 33. REM with the same operands gives 0xFFFFFFFF (−1).
- DIV 0x12345678 / 0: in cycle 0, result_valid = 1, result = 0xFFFFFFFF, stall_req = 0. REMU gives 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF: same cycle, result 0x80000000. REM gives 0.
- Flush at cycle 10 of a DIVU:
  - stall_req = 0 from cycle 11.
  - No result_valid ever.
  - A new DIVU 9 / 3 started at cycle 12 gives result 3 at cycle 45.
- rst pulsed at cycle 5 of a run:
  - Cycle 6: IDLE, all outputs 0.
  - Operands changed during RUN of a later op do not alter its result.
